stack_controller: RTL and testbench

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stack_ctrl_pkg.sv | 40 ++++
 rtl/stack_ctrl_outdec.sv | 89 ++++++++
 rtl/stack_controller.sv | 112 +++++++++++
 tb/tb_stack_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack-machine controller: state codes, opcodes and ALU operations.
package stack_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_POPA   = 4'd2,
        S_POPB   = 4'd3,
        S_EXEC   = 4'd4,
        S_WB     = 4'd5,
        S_MEMRD  = 4'd6,
        S_PUSHM  = 4'd7,
        S_POPM   = 4'd8,
        S_MEMWR  = 4'd9,
        S_JMP    = 4'd10,
        S_PEEK   = 4'd11,
        S_JZS    = 4'd12
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // Last state of every instruction; leaving one of these completes an instruction.
    function automatic logic is_terminal(input state_t s);
        return (s == S_WB) || (s == S_PUSHM) || (s == S_MEMWR) ||
               (s == S_JMP) || (s == S_JZS);
    endfunction

endpackage

// File: rtl/stack_ctrl_outdec.sv
// Combinational Moore output decoder: maps the current state (and the latched ALU op) to every control line.
module stack_ctrl_outdec
    import stack_ctrl_pkg::*;
(
    input  logic       rst,
    input  state_t     state,
    input  logic [1:0] alu_sel,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       SrcA,
    output logic       SrcB,
    output logic       LdA,
    output logic       LdB,
    output logic [1:0] AluOP,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSrc,
    output logic       tos,
    output logic       Push,
    output logic       Pop,
    output logic       MtoS
);

    // Reset overrides every state, and illegal codes fall through with all outputs low.
    always_comb begin
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IRWrite     = 1'b0;
        SrcA        = 1'b0;
        SrcB        = 1'b0;
        LdA         = 1'b0;
        LdB         = 1'b0;
        AluOP       = ALU_ADD;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 1'b0;
        tos         = 1'b0;
        Push        = 1'b0;
        Pop         = 1'b0;
        MtoS        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    memRead = 1'b1;
                    IRWrite = 1'b1;
                    SrcA    = 1'b1;
                    SrcB    = 1'b1;
                    PCWrite = 1'b1;
                end
                S_POPA, S_POPM: begin
                    Pop = 1'b1;
                    LdA = 1'b1;
                end
                S_POPB: begin
                    Pop = 1'b1;
                    LdB = 1'b1;
                end
                S_EXEC:  AluOP = alu_sel;
                S_WB:    Push  = 1'b1;
                S_MEMRD: begin
                    IorD    = 1'b1;
                    memRead = 1'b1;
                end
                S_PUSHM: begin
                    Push = 1'b1;
                    MtoS = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    memWrite = 1'b1;
                end
                S_JMP: begin
                    PCSrc   = 1'b1;
                    PCWrite = 1'b1;
                end
                S_PEEK:  tos = 1'b1;
                S_JZS: begin
                    PCSrc       = 1'b1;
                    PCWriteCond = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stack_controller.sv
// Multicycle stack-machine control FSM. Define STACK_CTRL_DBG_EN to expose state_dbg and the
// completed-instruction counter instr_cnt.
module stack_controller
    import stack_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] OPC,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       SrcA,
    output logic       SrcB,
    output logic       LdA,
    output logic       LdB,
    output logic [1:0] AluOP,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSrc,
    output logic       tos,
    output logic       Push,
    output logic       Pop,
    output logic       MtoS
`ifdef STACK_CTRL_DBG_EN
    ,
    output logic [3:0]  state_dbg,
    output logic [15:0] instr_cnt
`endif
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ALU op is captured while OPC is still valid so EXEC ignores later opcode changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_sel <= ALU_ADD;
        end else if (state == S_DECODE || state == S_POPA) begin
            alu_sel <= OPC[1:0];
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (OPC)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: next_state = S_POPA;
                    OP_PUSH: next_state = S_MEMRD;
                    OP_POP:  next_state = S_POPM;
                    OP_JMP:  next_state = S_JMP;
                    OP_JZ:   next_state = S_PEEK;
                    default: next_state = S_FETCH;
                endcase
            end
            S_POPA:   next_state = (OPC == OP_NOT) ? S_EXEC : S_POPB;
            S_POPB:   next_state = S_EXEC;
            S_EXEC:   next_state = S_WB;
            S_MEMRD:  next_state = S_PUSHM;
            S_POPM:   next_state = S_MEMWR;
            S_PEEK:   next_state = S_JZS;
            default:  next_state = S_FETCH;
        endcase
    end

    stack_ctrl_outdec u_outdec (
        .rst         (rst),
        .state       (state),
        .alu_sel     (alu_sel),
        .IorD        (IorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .IRWrite     (IRWrite),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .LdA         (LdA),
        .LdB         (LdB),
        .AluOP       (AluOP),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .tos         (tos),
        .Push        (Push),
        .Pop         (Pop),
        .MtoS        (MtoS)
    );

`ifdef STACK_CTRL_DBG_EN
    assign state_dbg = state;

    // Counts only completed instructions; reset and illegal-state recovery do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt <= 16'd0;
        end else if (next_state == S_FETCH && is_terminal(state)) begin
            instr_cnt <= instr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_controller.sv
// Directed self-checking bench for stack_controller; control lines are checked cycle by cycle
// against hand-written per-state patterns.
module tb_stack_controller;

    logic       clk;
    logic       rst;
    logic [2:0] OPC;
    logic       IorD, memRead, memWrite, IRWrite, SrcA, SrcB, LdA, LdB;
    logic [1:0] AluOP;
    logic       PCWrite, PCWriteCond, PCSrc, tos, Push, Pop, MtoS;
`ifdef STACK_CTRL_DBG_EN
    logic [3:0]  state_dbg;
    logic [15:0] instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Bit order: IorD memRead memWrite IRWrite SrcA SrcB LdA LdB AluOP[1:0] PCWrite PCWriteCond PCSrc tos Push Pop MtoS
    logic [16:0] ctl;
    assign ctl = {IorD, memRead, memWrite, IRWrite, SrcA, SrcB, LdA, LdB, AluOP,
                  PCWrite, PCWriteCond, PCSrc, tos, Push, Pop, MtoS};

    localparam logic [16:0] V_ZERO   = 17'b0_0_0_0_0_0_0_0_00_0_0_0_0_0_0_0;
    localparam logic [16:0] V_FETCH  = 17'b0_1_0_1_1_1_0_0_00_1_0_0_0_0_0_0;
    localparam logic [16:0] V_POPA   = 17'b0_0_0_0_0_0_1_0_00_0_0_0_0_0_1_0;
    localparam logic [16:0] V_POPB   = 17'b0_0_0_0_0_0_0_1_00_0_0_0_0_0_1_0;
    localparam logic [16:0] V_EX_ADD = 17'b0_0_0_0_0_0_0_0_00_0_0_0_0_0_0_0;
    localparam logic [16:0] V_EX_SUB = 17'b0_0_0_0_0_0_0_0_01_0_0_0_0_0_0_0;
    localparam logic [16:0] V_EX_NOT = 17'b0_0_0_0_0_0_0_0_11_0_0_0_0_0_0_0;
    localparam logic [16:0] V_WB     = 17'b0_0_0_0_0_0_0_0_00_0_0_0_0_1_0_0;
    localparam logic [16:0] V_MEMRD  = 17'b1_1_0_0_0_0_0_0_00_0_0_0_0_0_0_0;
    localparam logic [16:0] V_PUSHM  = 17'b0_0_0_0_0_0_0_0_00_0_0_0_0_1_0_1;
    localparam logic [16:0] V_MEMWR  = 17'b1_0_1_0_0_0_0_0_00_0_0_0_0_0_0_0;
    localparam logic [16:0] V_JMP    = 17'b0_0_0_0_0_0_0_0_00_1_0_1_0_0_0_0;
    localparam logic [16:0] V_PEEK   = 17'b0_0_0_0_0_0_0_0_00_0_0_0_1_0_0_0;
    localparam logic [16:0] V_JZS    = 17'b0_0_0_0_0_0_0_0_00_0_1_1_0_0_0_0;

    stack_controller dut (
        .clk         (clk),
        .rst         (rst),
        .OPC         (OPC),
        .IorD        (IorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .IRWrite     (IRWrite),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .LdA         (LdA),
        .LdB         (LdB),
        .AluOP       (AluOP),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .tos         (tos),
        .Push        (Push),
        .Pop         (Pop),
        .MtoS        (MtoS)
`ifdef STACK_CTRL_DBG_EN
        ,
        .state_dbg   (state_dbg),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        OPC = 3'b000;
        step();
        step();
        checks++;
        if (ctl !== V_ZERO) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", ctl, V_ZERO);
        end
`ifdef STACK_CTRL_DBG_EN
        checks++;
        if (instr_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %0d expected 0", instr_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL first_fetch: got %b expected %b", ctl, V_FETCH);
        end
    endtask

    task automatic test_add();
        logic [16:0] exp [6];
        exp[0] = V_FETCH; exp[1] = V_ZERO; exp[2] = V_POPA;
        exp[3] = V_POPB;  exp[4] = V_EX_ADD; exp[5] = V_WB;
        OPC = 3'b000;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ctl !== exp[i]) begin
                errors++;
                $display("[TB] FAIL add_cycle%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL add_latency: got %b expected %b", ctl, V_FETCH);
        end
    endtask

    task automatic test_sub_opc_hold();
        logic [16:0] exp [6];
        exp[0] = V_FETCH; exp[1] = V_ZERO; exp[2] = V_POPA;
        exp[3] = V_POPB;  exp[4] = V_EX_SUB; exp[5] = V_WB;
        OPC = 3'b001;
        for (int i = 0; i < 6; i++) begin
            // Opcode is scrambled once it may no longer be sampled.
            if (i == 3) OPC = 3'b011;
            checks++;
            if (ctl !== exp[i]) begin
                errors++;
                $display("[TB] FAIL sub_hold_cycle%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL sub_latency: got %b expected %b", ctl, V_FETCH);
        end
    endtask

    task automatic test_not();
        logic [16:0] exp [5];
        int pops;
        exp[0] = V_FETCH; exp[1] = V_ZERO; exp[2] = V_POPA;
        exp[3] = V_EX_NOT; exp[4] = V_WB;
        pops = 0;
        OPC = 3'b011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== exp[i]) begin
                errors++;
                $display("[TB] FAIL not_cycle%0d: got %b expected %b", i, ctl, exp[i]);
            end
            if (Pop === 1'b1) pops++;
            step();
        end
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL not_latency: got %b expected %b", ctl, V_FETCH);
        end
        checks++;
        if (pops !== 1) begin
            errors++;
            $display("[TB] FAIL not_pop_count: got %0d expected 1", pops);
        end
    endtask

    task automatic test_push_pop();
        logic [16:0] exp [8];
        exp[0] = V_FETCH; exp[1] = V_ZERO; exp[2] = V_MEMRD; exp[3] = V_PUSHM;
        exp[4] = V_FETCH; exp[5] = V_ZERO; exp[6] = V_POPA;  exp[7] = V_MEMWR;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) OPC = 3'b100;
            if (i == 4) OPC = 3'b101;
            checks++;
            if (ctl !== exp[i]) begin
                errors++;
                $display("[TB] FAIL pushpop_cycle%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL pop_latency: got %b expected %b", ctl, V_FETCH);
        end
    endtask

    task automatic test_jmp_jz();
        logic [16:0] exp [7];
        exp[0] = V_FETCH; exp[1] = V_ZERO; exp[2] = V_JMP;
        exp[3] = V_FETCH; exp[4] = V_ZERO; exp[5] = V_PEEK; exp[6] = V_JZS;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) OPC = 3'b110;
            if (i == 3) OPC = 3'b111;
            checks++;
            if (ctl !== exp[i]) begin
                errors++;
                $display("[TB] FAIL jmpjz_cycle%0d: got %b expected %b", i, ctl, exp[i]);
            end
            step();
        end
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL jz_latency: got %b expected %b", ctl, V_FETCH);
        end
    endtask

    task automatic test_reset_mid();
        int pushes;
        OPC = 3'b000;
        step();
        step();
        step();
        checks++;
        if (ctl !== V_POPB) begin
            errors++;
            $display("[TB] FAIL mid_at_popb: got %b expected %b", ctl, V_POPB);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== V_ZERO) begin
            errors++;
            $display("[TB] FAIL mid_forced_zero: got %b expected %b", ctl, V_ZERO);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL mid_fetch_next: got %b expected %b", ctl, V_FETCH);
        end
`ifdef STACK_CTRL_DBG_EN
        checks++;
        if (instr_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_cnt_cleared: got %0d expected 0", instr_cnt);
        end
`endif
        // Three JMPs (3 cycles each) complete after the abandoned ADD.
        pushes = 0;
        OPC = 3'b110;
        for (int i = 0; i < 9; i++) begin
            if (Push === 1'b1) pushes++;
            step();
        end
        checks++;
        if (pushes !== 0) begin
            errors++;
            $display("[TB] FAIL mid_no_push: got %0d pushes expected 0", pushes);
        end
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("[TB] FAIL mid_three_jmp: got %b expected %b", ctl, V_FETCH);
        end
`ifdef STACK_CTRL_DBG_EN
        checks++;
        if (instr_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL mid_cnt_three: got %0d expected 3", instr_cnt);
        end
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("[TB] FAIL mid_state_dbg: got %0d expected 0", state_dbg);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        OPC = 3'b000;
        test_reset();
        test_add();
        test_sub_opc_hold();
        test_not();
        test_push_pop();
        test_jmp_jz();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
